bus_timer: RTL and testbench

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/bus_timer_pkg.sv | 30 +++
 rtl/bus_timer.sv | 133 +++++++++++++
 tb/tb_bus_timer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_timer_pkg.sv
// Shared timer definitions: register offsets, CTRL bit positions,
// MODE codes and the sequencing state encoding.
package bus_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // Only the 01 code reloads; the 1x codes fall back to one-shot.
  function automatic logic is_auto(input logic [1:0] mode);
    return (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Bus-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable, registered interrupt output.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | stopped, COUNT frozen; leaves when EN is set
// LOAD  | COUNT <= PRESET (abandoned if EN dropped meanwhile)
// CNT   | decrement COUNT down to terminal count (0 or 1)
// INT   | raise the flag; one-shot clears EN, auto-reload reloads
module bus_timer
  import bus_timer_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Sel,
  input  logic        We,
  input  logic [1:0]  Addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  timer_state_e state_q, state_d;

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        irq_q, irq_d;

  logic wr_ctrl, wr_preset;
  logic en, auto_mode;
  logic flag_set, en_clr;

  assign wr_ctrl   = Sel & We & (Addr == ADDR_CTRL);
  assign wr_preset = Sel & We & (Addr == ADDR_PRESET);
  assign en        = ctrl_q[CTRL_EN];
  assign auto_mode = is_auto(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]);

  // Next-state and COUNT update; terminal count covers both 0 and 1 so a
  // zero PRESET behaves like one and COUNT can never wrap.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    flag_set = 1'b0;
    en_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          count_d = preset_q;
          state_d = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        flag_set = 1'b1;
        if (auto_mode) begin
          state_d = ST_LOAD;
        end else begin
          en_clr  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register-file update: a bus write to CTRL beats the FSM clearing EN,
  // while the FSM setting the flag beats a write clearing it.
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    flag_d   = flag_q;
    if (en_clr)    ctrl_d[CTRL_EN] = 1'b0;
    if (wr_ctrl)   ctrl_d = WD[3:0];
    if (wr_preset) preset_d = WD;
    if (wr_ctrl || wr_preset) flag_d = 1'b0;
    if (auto_mode) flag_d = 1'b0;
    if (flag_set)  flag_d = 1'b1;
    irq_d = flag_d & ctrl_d[CTRL_IM];
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and interrupt registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  // Zero-latency read mux; Sel is deliberately not involved.
  always_comb begin
    RD = 32'd0;
    case (Addr)
      ADDR_CTRL:   RD = {28'd0, ctrl_q};
      ADDR_PRESET: RD = preset_q;
      ADDR_COUNT:  RD = count_q;
      default:     RD = 32'd0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: stimulus pushes hand-computed expectations
// into a queue, a monitor pops and compares on each observation strobe.
module tb_bus_timer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Sel;
  logic        We;
  logic [1:0]  Addr;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  event  chk_ev;

  int cnt33 [0:8]  = '{0, 0, 5, 4, 3, 2, 1, 0, 0};
  int cnt34 [0:16] = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
  int irq34 [0:16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int cnt23 [0:3]  = '{2, 1, 0, 0};
  int irq23 [0:3]  = '{0, 0, 0, 1};
  int cnt36 [0:6]  = '{99, 99, 2, 1, 0, 0, 0};

  bus_timer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Sel   (Sel),
    .We    (We),
    .Addr  (Addr),
    .WD    (WD),
    .RD    (RD),
    .IRQ   (IRQ)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Sel = 1'b1; We = 1'b1; Addr = a; WD = d;
    tick();
    Sel = 1'b0; We = 1'b0;
  endtask

  task automatic chk(input logic [1:0] a, input logic [31:0] rd, input logic irq, input string nm);
    exp_t e;
    Addr = a;
    #1;
    e.rd  = rd;
    e.irq = irq;
    exp_q.push_back(e);
    name_q.push_back(nm);
    -> chk_ev;
    #1;
  endtask

  // Monitor: compare the DUT outputs against the oldest pending expectation.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(chk_ev);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: strobe with empty queue, RD=%08h IRQ=%b", RD, IRQ);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (RD !== e.rd || IRQ !== e.irq) begin
          errors++;
          $display("FAIL %s: got RD=%08h IRQ=%b, want RD=%08h IRQ=%b",
                   nm, RD, IRQ, e.rd, e.irq);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0; Sel = 1'b0; We = 1'b0; Addr = 2'd0; WD = 32'd0;
    tick(); tick();
    chk(2'd0, 32'd0, 1'b0, "rst_ctrl");
    chk(2'd1, 32'd0, 1'b0, "rst_preset");
    chk(2'd2, 32'd0, 1'b0, "rst_count");
    chk(2'd3, 32'd0, 1'b0, "rst_rsvd");
    tick();
    Reset = 1'b1;
    chk(2'd0, 32'd0, 1'b0, "idle_ctrl");
    chk(2'd1, 32'd0, 1'b0, "idle_preset");
    chk(2'd2, 32'd0, 1'b0, "idle_count");

    // First write after deassertion lands on the first edge.
    wr(2'd1, 32'd5);
    chk(2'd1, 32'd5, 1'b0, "first_wr");

    // One-shot, PRESET=5: IRQ appears 8 edges after the CTRL write.
    wr(2'd0, 32'h9);
    for (int k = 0; k <= 8; k++) begin
      chk(2'd2, cnt33[k], (k == 8), "os_count");
      if (k < 8) tick();
    end
    chk(2'd0, 32'h8, 1'b1, "os_ctrl");
    tick(); tick();
    chk(2'd2, 32'd0, 1'b1, "os_irq_hold");
    wr(2'd1, 32'd3);
    chk(2'd1, 32'd3, 1'b0, "os_irq_drop");

    // Auto-reload, PRESET=3: one-cycle pulse every 5 cycles.
    wr(2'd0, 32'hB);
    for (int k = 0; k <= 16; k++) begin
      chk(2'd2, cnt34[k], irq34[k][0], "ar_count");
      if (k < 16) tick();
    end
    chk(2'd0, 32'hB, 1'b1, "ar_ctrl_en");
    wr(2'd0, 32'h8);
    chk(2'd2, 32'd3, 1'b0, "ar_stop");
    tick();
    chk(2'd2, 32'd3, 1'b0, "ar_stop_hold");

    // CTRL writes landing on the INT edge in one-shot mode.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    tick(); tick(); tick();
    chk(2'd2, 32'd0, 1'b0, "os1_int");
    wr(2'd0, 32'h8);
    chk(2'd0, 32'h8, 1'b1, "coinc_clr_ctrl");
    wr(2'd0, 32'h9);
    tick(); tick(); tick();
    wr(2'd0, 32'h9);
    chk(2'd0, 32'h9, 1'b1, "coinc_keep_ctrl");
    wr(2'd0, 32'h0);
    chk(2'd0, 32'h0, 1'b0, "coinc_stop");
    tick();

    // PRESET=0 times out like PRESET=1 and never wraps.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 0; k <= 4; k++) begin
      chk(2'd2, 32'd0, (k == 4), "p0_count");
      if (k < 4) tick();
    end

    // PRESET write mid-count does not disturb the running COUNT.
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    tick(); tick();
    chk(2'd2, 32'd4, 1'b0, "pre_mid_start");
    wr(2'd1, 32'd9);
    chk(2'd1, 32'd9, 1'b0, "pre_mid_preset");
    chk(2'd2, 32'd3, 1'b0, "pre_mid_count");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk(2'd2, cnt23[k], irq23[k][0], "pre_mid_run");
    end
    wr(2'd0, 32'h9);
    tick(); tick();
    chk(2'd2, 32'd9, 1'b0, "pre_new_load");
    wr(2'd0, 32'h0);
    tick();

    // Stop at COUNT=40 (write issued on the edge that takes COUNT 41->40).
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    repeat (61) tick();
    chk(2'd2, 32'd41, 1'b0, "hold_pre");
    wr(2'd0, 32'h8);
    chk(2'd2, 32'd40, 1'b0, "hold_stop");
    repeat (5) tick();
    chk(2'd2, 32'd40, 1'b0, "hold_keep");
    chk(2'd0, 32'h8, 1'b0, "hold_ctrl");
    wr(2'd0, 32'h9);
    tick();
    chk(2'd2, 32'd40, 1'b0, "restart_load");
    tick();
    chk(2'd2, 32'd100, 1'b0, "restart_reload");
    wr(2'd0, 32'h0);

    // IM=0: flag fires silently, and setting IM alone clears it.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 0; k <= 6; k++) begin
      chk(2'd2, cnt36[k], 1'b0, "im0_count");
      if (k < 6) tick();
    end
    chk(2'd0, 32'h0, 1'b0, "im0_ctrl");
    wr(2'd0, 32'h8);
    chk(2'd0, 32'h8, 1'b0, "im_set_noirq");
    tick();
    chk(2'd2, 32'd0, 1'b0, "im_set_noirq2");

    // Reset pulse mid-count.
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    repeat (15) tick();
    chk(2'd2, 32'd7, 1'b0, "rst_mid_count");
    Reset = 1'b0;
    chk(2'd0, 32'd0, 1'b0, "rst_mid_ctrl");
    chk(2'd1, 32'd0, 1'b0, "rst_mid_preset");
    chk(2'd2, 32'd0, 1'b0, "rst_mid_cnt0");
    tick();
    Reset = 1'b1;
    for (int k = 0; k < 25; k++) begin
      chk(2'd2, 32'd0, 1'b0, "post_rst");
      tick();
    end
    wr(2'd2, 32'h1234);
    chk(2'd2, 32'd0, 1'b0, "cnt_ro");
    wr(2'd3, 32'hFFFF);
    chk(2'd3, 32'd0, 1'b0, "rsvd_rd");
    wr(2'd1, 32'hDEADBEEF);
    chk(2'd1, 32'hDEADBEEF, 1'b0, "preset_full");
    chk(2'd3, 32'd0, 1'b0, "rsvd_vs_preset");
    chk(2'd0, 32'd0, 1'b0, "ctrl_after_ro");

    #20;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never observed, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
